// File: rtl/dft_reorder_buf_pkg.sv
// dft_reorder_buf_pkg: shared sample width, bank depth, index width and read FSM state type
package dft_reorder_buf_pkg;
  localparam int FFT_OUT_WIDTH = 16;
  localparam int MAX_LEN = 2048;
  localparam int IDX_W = 12;
  typedef enum logic [1:0] {RD_IDLE, RD_READ, RD_DRAIN} rd_state_t;
endpackage

// File: rtl/dft_reorder_buf_ram.sv
// dft_rdbuf_ram: simple dual-port RAM holding both ping-pong banks, addressed {bank, index}, one-cycle read
module dft_rdbuf_ram #(
  parameter int WIDTH = 32,
  parameter int AW = 12
) (
  input  logic             clk_sys,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [1<<AW];
  logic [WIDTH-1:0] r_rdata;
  // write port and registered read port; contents are never reset
  always_ff @(posedge clk_sys) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/dft_reorder_buf.sv
// dft_reorder_buf: ping-pong reorder of DFT bins into natural order; define DFT_REORDER_STATS_EN for the drop counter
module dft_reorder_buf #(
  parameter int FFT_OUT_WIDTH = dft_reorder_buf_pkg::FFT_OUT_WIDTH,
  parameter int MAX_LEN = dft_reorder_buf_pkg::MAX_LEN
) (
  input  logic                                   clk_sys,
  input  logic                                   rst_sys_n,
  input  logic                                   block_sync_i,
  input  logic                                   data_val_i,
  input  logic signed [FFT_OUT_WIDTH-1:0]        data_real_i,
  input  logic signed [FFT_OUT_WIDTH-1:0]        data_imag_i,
  input  logic [dft_reorder_buf_pkg::IDX_W-1:0]  data_index_i,
  input  logic [dft_reorder_buf_pkg::IDX_W-1:0]  trans_len_i,
  input  logic                                   out_rdy_i,
  output logic                                   block_sync_o,
  output logic                                   data_val_o,
  output logic signed [FFT_OUT_WIDTH-1:0]        data_real_o,
  output logic signed [FFT_OUT_WIDTH-1:0]        data_imag_o,
  output logic [dft_reorder_buf_pkg::IDX_W-1:0]  data_index_o,
  output logic [dft_reorder_buf_pkg::IDX_W-1:0]  trans_len_o,
  output logic                                   ovf_o,
  output logic [15:0]                            drop_cnt_o
);
  import dft_reorder_buf_pkg::*;
  localparam int LW = $clog2(MAX_LEN);
  localparam int DW = 2 * FFT_OUT_WIDTH;
  localparam int EW = 1 + 2 * IDX_W + DW;
  logic [1:0]       r_full;
  logic [IDX_W-1:0] r_len [2];
  logic             r_wr_bank, r_rd_bank;
  logic [IDX_W-1:0] r_wr_cnt;
  logic             r_ovf;
  rd_state_t        r_state, w_state_nxt;
  logic [IDX_W-1:0] r_rd_addr;
  logic             r_p_val, r_p_sync;
  logic [IDX_W-1:0] r_p_idx, r_p_len;
  logic             r_val, r_sk_val;
  logic [EW-1:0]    r_out, r_sk;
  logic [IDX_W-1:0] w_len_eff, w_cnt_nxt;
  logic             w_acc, w_we, w_set, w_clr, w_ovf, w_issue, w_pop, w_rd_last, w_o_sync;
  logic [1:0]       w_set_vec, w_clr_vec, w_occ;
  logic [DW-1:0]    w_rdata;
  logic [EW-1:0]    w_in;

  assign w_acc     = data_val_i & ~r_full[r_wr_bank];
  assign w_ovf     = data_val_i & r_full[r_wr_bank];
  assign w_len_eff = block_sync_i ? trans_len_i : r_len[r_wr_bank];
  assign w_we      = w_acc & (data_index_i < w_len_eff);
  assign w_cnt_nxt = (block_sync_i ? '0 : r_wr_cnt) + IDX_W'(w_we);
  assign w_set     = w_we & (w_cnt_nxt == w_len_eff);
  assign w_set_vec = w_set ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr_vec = w_clr ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

  // write side: latch N on block start, count accepted samples, hand the bank over when complete
  always_ff @(posedge clk_sys or negedge rst_sys_n)
    if (!rst_sys_n) begin
      r_wr_bank <= 1'b0;
      r_wr_cnt  <= '0;
      r_len[0]  <= '0;
      r_len[1]  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_ovf <= w_ovf;
      if (w_acc && block_sync_i) r_len[r_wr_bank] <= trans_len_i;
      if (w_acc) r_wr_cnt <= w_set ? '0 : w_cnt_nxt;
      if (w_set) r_wr_bank <= ~r_wr_bank;
    end

  // bank full flags: a read-side clear is applied before a write-side set on the same bank
  always_ff @(posedge clk_sys or negedge rst_sys_n)
    if (!rst_sys_n) r_full <= 2'b00;
    else r_full <= (r_full & ~w_clr_vec) | w_set_vec;

  assign w_pop     = r_val & out_rdy_i;
  assign w_occ     = 2'(r_val) + 2'(r_sk_val) + 2'(r_p_val) - 2'(w_pop);
  assign w_rd_last = r_rd_addr == r_len[r_rd_bank] - IDX_W'(1);

  // read FSM state register
  always_ff @(posedge clk_sys or negedge rst_sys_n)
    if (!rst_sys_n) r_state <= RD_IDLE;
    else r_state <= w_state_nxt;

  // read FSM: issue a read only when the skid buffer can absorb it, release the bank once reads land
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      RD_IDLE:  if (r_full[r_rd_bank]) w_state_nxt = RD_READ;
      RD_READ: begin
        w_issue = w_occ < 2'd2;
        if (w_issue && w_rd_last) w_state_nxt = RD_DRAIN;
      end
      RD_DRAIN: if (!r_p_val) begin
        w_clr       = 1'b1;
        w_state_nxt = RD_IDLE;
      end
      default:  w_state_nxt = RD_IDLE;
    endcase
  end

  // read address counter and the tag pipeline that travels alongside the RAM read
  always_ff @(posedge clk_sys or negedge rst_sys_n)
    if (!rst_sys_n) begin
      r_rd_bank <= 1'b0;
      r_rd_addr <= '0;
      r_p_val   <= 1'b0;
      r_p_sync  <= 1'b0;
      r_p_idx   <= '0;
      r_p_len   <= '0;
    end else begin
      if (w_clr) r_rd_bank <= ~r_rd_bank;
      if (w_issue) r_rd_addr <= w_rd_last ? '0 : r_rd_addr + IDX_W'(1);
      r_p_val  <= w_issue;
      r_p_sync <= w_issue & (r_rd_addr == '0);
      r_p_idx  <= r_rd_addr;
      r_p_len  <= r_len[r_rd_bank];
    end

  dft_rdbuf_ram #(.WIDTH(DW), .AW(LW + 1)) u_ram (
    .clk_sys (clk_sys),
    .i_we    (w_we),
    .i_waddr ({r_wr_bank, data_index_i[LW-1:0]}),
    .i_wdata ({data_real_i, data_imag_i}),
    .i_re    (w_issue),
    .i_raddr ({r_rd_bank, r_rd_addr[LW-1:0]}),
    .o_rdata (w_rdata)
  );

  assign w_in = {r_p_sync, r_p_idx, r_p_len, w_rdata};

  // two-entry output skid buffer: head drives the outputs, second entry catches the in-flight read
  always_ff @(posedge clk_sys or negedge rst_sys_n)
    if (!rst_sys_n) begin
      r_val    <= 1'b0;
      r_sk_val <= 1'b0;
      r_out    <= '0;
      r_sk     <= '0;
    end else if (!r_val || w_pop) begin
      r_val    <= r_sk_val | r_p_val;
      r_out    <= r_sk_val ? r_sk : w_in;
      r_sk_val <= r_sk_val & r_p_val;
      if (r_sk_val) r_sk <= w_in;
    end else if (r_p_val) begin
      r_sk_val <= 1'b1;
      r_sk     <= w_in;
    end

  assign {w_o_sync, data_index_o, trans_len_o, data_real_o, data_imag_o} = r_out;
  assign block_sync_o = w_o_sync & r_val;
  assign data_val_o   = r_val;
  assign ovf_o        = r_ovf;

`ifdef DFT_REORDER_STATS_EN
  logic [15:0] r_drop_cnt;
  // count ovf_o pulses, holding at all-ones
  always_ff @(posedge clk_sys or negedge rst_sys_n)
    if (!rst_sys_n) r_drop_cnt <= '0;
    else if (r_ovf && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
  assign drop_cnt_o = r_drop_cnt;
`else
  assign drop_cnt_o = '0;
`endif
endmodule

// File: tb/tb_dft_reorder_buf.sv
// tb_dft_reorder_buf: directed self-checking bench for the DFT reorder buffer
module tb_dft_reorder_buf;
  localparam int W = dft_reorder_buf_pkg::FFT_OUT_WIDTH;
`ifdef DFT_REORDER_STATS_EN
  localparam logic [15:0] EXP_DROP = 16'd12;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif
  localparam int PERM12 [12] = '{0, 6, 3, 9, 1, 7, 4, 10, 2, 8, 5, 11};

  logic clk_sys = 1'b0, rst_sys_n = 1'b0, block_sync_i = 1'b0, data_val_i = 1'b0, out_rdy_i = 1'b1;
  logic signed [W-1:0] data_real_i = '0, data_imag_i = '0;
  logic [11:0] data_index_i = '0, trans_len_i = '0;
  logic block_sync_o, data_val_o, ovf_o;
  logic signed [W-1:0] data_real_o, data_imag_o;
  logic [11:0] data_index_o, trans_len_o;
  logic [15:0] drop_cnt_o;

  int n_chk = 0, n_err = 0, n_ovf = 0;
  logic [11:0] q_idx[$], q_len[$];
  logic q_sync[$];
  logic [W-1:0] q_re[$], q_im[$];
  logic p_stall = 1'b0;
  logic [2*W+24:0] p_snap = '0;

  dft_reorder_buf dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n), .block_sync_i(block_sync_i), .data_val_i(data_val_i),
    .data_real_i(data_real_i), .data_imag_i(data_imag_i), .data_index_i(data_index_i),
    .trans_len_i(trans_len_i), .out_rdy_i(out_rdy_i), .block_sync_o(block_sync_o),
    .data_val_o(data_val_o), .data_real_o(data_real_o), .data_imag_o(data_imag_o),
    .data_index_o(data_index_o), .trans_len_o(trans_len_o), .ovf_o(ovf_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [W-1:0] f_re(input int b, input int k);
    return W'(b * 4096 + k * 3);
  endfunction

  function automatic logic [W-1:0] f_im(input int b, input int k);
    return W'(-(k * 5) - b * 7);
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h need %0h", tag, got, exp);
    end
  endtask

  // monitor: record transfers, count ovf cycles, and require the held word to stay put while stalled
  always @(negedge clk_sys) begin
    if (ovf_o) n_ovf++;
    if (p_stall) begin
      n_chk++;
      assert (data_val_o === 1'b1 && {block_sync_o, data_index_o, trans_len_o, data_real_o, data_imag_o} === p_snap) else begin
        n_err++;
        $error("FAIL stall_hold: got val=%b word=%h need val=1 word=%h", data_val_o,
               {block_sync_o, data_index_o, trans_len_o, data_real_o, data_imag_o}, p_snap);
      end
    end
    p_stall = data_val_o & ~out_rdy_i;
    p_snap  = {block_sync_o, data_index_o, trans_len_o, data_real_o, data_imag_o};
    if (data_val_o && out_rdy_i) begin
      q_idx.push_back(data_index_o);
      q_len.push_back(trans_len_o);
      q_sync.push_back(block_sync_o);
      q_re.push_back(data_real_o);
      q_im.push_back(data_imag_o);
    end
  end

  task automatic send(input int b, input int n, input int m);
    for (int k = 0; k < m; k++) begin
      @(posedge clk_sys);
      #1;
      data_val_i   = 1'b1;
      block_sync_i = (k == 0);
      trans_len_i  = 12'(n);
      data_index_i = 12'(n == 12 ? PERM12[k] : (k * 7) % n);
      data_real_i  = f_re(b, int'(data_index_i));
      data_imag_i  = f_im(b, int'(data_index_i));
    end
    @(posedge clk_sys);
    #1;
    data_val_i   = 1'b0;
    block_sync_i = 1'b0;
  endtask

  task automatic expect_blk(input int b, input int n);
    int t;
    logic [11:0] gi, gl;
    logic gs;
    logic [W-1:0] gr, gm;
    t = 0;
    while (q_idx.size() < n && t < 8 * n + 200) begin
      @(posedge clk_sys);
      t++;
    end
    n_chk++;
    assert (q_idx.size() >= n) else begin
      n_err++;
      $error("FAIL blk%0d_count: got %0d samples need %0d", b, q_idx.size(), n);
    end
    for (int k = 0; k < n && q_idx.size() > 0; k++) begin
      gi = q_idx.pop_front();
      gl = q_len.pop_front();
      gs = q_sync.pop_front();
      gr = q_re.pop_front();
      gm = q_im.pop_front();
      n_chk++;
      assert ({gs, gi, gl, gr, gm} === {k == 0, 12'(k), 12'(n), f_re(b, k), f_im(b, k)}) else begin
        n_err++;
        $error("FAIL blk%0d_s%0d: got sync=%b idx=%0d len=%0d re=%h im=%h need sync=%b idx=%0d len=%0d re=%h im=%h",
               b, k, gs, gi, gl, gr, gm, k == 0, k, n, f_re(b, k), f_im(b, k));
      end
    end
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_outs", {data_val_o, block_sync_o, ovf_o, data_index_o, trans_len_o, data_real_o, data_imag_o, drop_cnt_o}, '0);
    rst_sys_n = 1'b1;

    send(1, 12, 12);
    @(posedge clk_sys);
    @(posedge clk_sys);
    #1;
    chk("lat_early", data_val_o, 0);
    @(posedge clk_sys);
    #1;
    chk("lat_first", {data_val_o, block_sync_o, data_index_o}, {1'b1, 1'b1, 12'd0});
    expect_blk(1, 12);

    n_ovf = 0;
    send(2, 1296, 1296);
    send(3, 1296, 1296);
    expect_blk(2, 1296);
    expect_blk(3, 1296);
    chk("b2b_ovf", n_ovf, 0);

    fork
      send(4, 24, 24);
      repeat (150) begin
        @(posedge clk_sys);
        #1;
        out_rdy_i = ~out_rdy_i;
      end
    join
    out_rdy_i = 1'b1;
    expect_blk(4, 24);

    out_rdy_i = 1'b0;
    n_ovf = 0;
    send(5, 12, 12);
    send(6, 12, 12);
    send(7, 12, 12);
    repeat (3) @(posedge clk_sys);
    #1;
    chk("ovf_pulses", n_ovf, 12);
    chk("drop_cnt", drop_cnt_o, EXP_DROP);
    out_rdy_i = 1'b1;
    expect_blk(5, 12);
    expect_blk(6, 12);
    repeat (40) @(posedge clk_sys);
    #1;
    chk("drop_q_empty", q_idx.size(), 0);

    send(8, 36, 5);
    send(9, 36, 36);
    expect_blk(9, 36);
    repeat (40) @(posedge clk_sys);
    #1;
    chk("partial_q_empty", q_idx.size(), 0);

    send(10, 2048, 2048);
    t = 0;
    while (q_idx.size() < 100 && t < 500) begin
      @(posedge clk_sys);
      t++;
    end
    chk("pre_rst_stream", {q_idx.size() >= 100, data_val_o}, 2'b11);
    #1 rst_sys_n = 1'b0;
    #1;
    chk("rst_async", {data_val_o, block_sync_o, ovf_o, data_index_o, trans_len_o, data_real_o, data_imag_o, drop_cnt_o}, '0);
    repeat (2) @(posedge clk_sys);
    #1 rst_sys_n = 1'b1;
    q_idx.delete();
    q_len.delete();
    q_sync.delete();
    q_re.delete();
    q_im.delete();
    repeat (60) @(posedge clk_sys);
    #1;
    chk("post_rst_idle", {q_idx.size() != 0, data_val_o}, 0);
    send(11, 12, 12);
    expect_blk(11, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
